// File: rtl/arb_pkg.sv
// Shared types and constants for the fetch/memory-stage port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_IF,
        ARB_BUSY_MEM
    } arb_state_e;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    localparam int unsigned MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational IF/MEM priority select with a saturating fetch-starvation counter.
module arb_prio_sel
    import arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic flush,
    input  logic if_req,
    input  logic mem_req,
    output logic gnt,
    output logic gnt_owner
);

    localparam logic [3:0] WaitMax = 4'(MAX_WAIT);

    logic [3:0] wait_q, wait_d;
    logic       act;
    logic       if_win;

    always_comb begin
        act       = idle && !reset;
        // A redirect in flight makes the current fetch address stale, so it may not win.
        if_win    = if_req && !flush && (!mem_req || wait_q == WaitMax);
        gnt       = act && (if_win || mem_req);
        gnt_owner = if_win ? OWN_IF : OWN_MEM;
        wait_d    = wait_q;
        if (act) begin
            if (!if_req || if_win) begin
                wait_d = '0;
            end else if (mem_req && wait_q != WaitMax) begin
                wait_d = wait_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and memory stage; drops fetch responses killed by FLUSH.
// Optional performance counters are enabled with `define ARB_PERF_CNT_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FLUSH,
    input  logic                IF_REQ,
    input  logic [ADDR_W-1:0]   IF_ADDR,
    output logic                IF_GNT,
    output logic                IF_RVALID,
    output logic [DATA_W-1:0]   IF_RDATA,
    output logic                IF_ERR,
    input  logic                MEM_REQ,
    input  logic                MEM_WE,
    input  logic [ADDR_W-1:0]   MEM_ADDR,
    input  logic [DATA_W-1:0]   MEM_WDATA,
    input  logic [DATA_W/8-1:0] MEM_WSTRB,
    output logic                MEM_GNT,
    output logic                MEM_RVALID,
    output logic [DATA_W-1:0]   MEM_RDATA,
    output logic                MEM_ERR,
    output logic                BUS_REQ,
    output logic                BUS_WE,
    output logic [ADDR_W-1:0]   BUS_ADDR,
    output logic [DATA_W-1:0]   BUS_WDATA,
    output logic [DATA_W/8-1:0] BUS_WSTRB,
    input  logic                BUS_ACK,
    input  logic [DATA_W-1:0]   BUS_RDATA,
    input  logic                BUS_ERR
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         PERF_IF_GNT,
    output logic [31:0]         PERF_MEM_GNT,
    output logic [31:0]         PERF_CONTEND
`endif
);

    arb_state_e          state_q, state_d;
    logic                kill_q, kill_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W/8-1:0] bus_wstrb_q, bus_wstrb_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                if_err_q, if_err_d;
    logic                mem_rvalid_q, mem_rvalid_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                mem_err_q, mem_err_d;
    logic                gnt, gnt_owner;
    logic                if_gnt, mem_gnt;
    logic [DATA_W-1:0]   resp_data;

    arb_prio_sel #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio_sel (
        .clk       (CLK),
        .reset     (RESET),
        .idle      (state_q == ARB_IDLE),
        .flush     (FLUSH),
        .if_req    (IF_REQ),
        .mem_req   (MEM_REQ),
        .gnt       (gnt),
        .gnt_owner (gnt_owner)
    );

    assign if_gnt    = gnt && (gnt_owner == OWN_IF);
    assign mem_gnt   = gnt && (gnt_owner == OWN_MEM);
    assign resp_data = BUS_ERR ? '0 : BUS_RDATA;

    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        if_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        if_err_d     = if_err_q;
        mem_rvalid_d = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        mem_err_d    = mem_err_q;
        case (state_q)
            ARB_IDLE: begin
                kill_d = 1'b0;
                if (if_gnt) begin
                    state_d     = ARB_BUSY_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = IF_ADDR;
                    bus_wdata_d = '0;
                    bus_wstrb_d = '0;
                end else if (mem_gnt) begin
                    state_d     = ARB_BUSY_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = MEM_WE;
                    bus_addr_d  = MEM_ADDR;
                    bus_wdata_d = MEM_WDATA;
                    bus_wstrb_d = MEM_WSTRB;
                end
            end
            ARB_BUSY_IF: begin
                if (FLUSH) begin
                    kill_d = 1'b1;
                end
                if (BUS_ACK) begin
                    state_d   = ARB_IDLE;
                    bus_req_d = 1'b0;
                    kill_d    = 1'b0;
                    // The transfer always completes; only the response to fetch is dropped.
                    if (!(kill_q || FLUSH)) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = resp_data;
                        if_err_d    = BUS_ERR;
                    end
                end
            end
            ARB_BUSY_MEM: begin
                if (BUS_ACK) begin
                    state_d      = ARB_IDLE;
                    bus_req_d    = 1'b0;
                    mem_rvalid_d = 1'b1;
                    mem_rdata_d  = resp_data;
                    mem_err_d    = BUS_ERR;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ARB_IDLE;
            kill_q       <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wstrb_q  <= '0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            if_err_q     <= 1'b0;
            mem_rvalid_q <= 1'b0;
            mem_rdata_q  <= '0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            mem_rvalid_q <= mem_rvalid_d;
            mem_rdata_q  <= mem_rdata_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign IF_GNT     = if_gnt;
    assign MEM_GNT    = mem_gnt;
    assign IF_RVALID  = if_rvalid_q;
    assign IF_RDATA   = if_rdata_q;
    assign IF_ERR     = if_err_q;
    assign MEM_RVALID = mem_rvalid_q;
    assign MEM_RDATA  = mem_rdata_q;
    assign MEM_ERR    = mem_err_q;
    assign BUS_REQ    = bus_req_q;
    assign BUS_WE     = bus_we_q;
    assign BUS_ADDR   = bus_addr_q;
    assign BUS_WDATA  = bus_wdata_q;
    assign BUS_WSTRB  = bus_wstrb_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_mem_q, perf_cont_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            perf_if_q   <= '0;
            perf_mem_q  <= '0;
            perf_cont_q <= '0;
        end else begin
            if (if_gnt) begin
                perf_if_q <= perf_if_q + 32'd1;
            end
            if (mem_gnt) begin
                perf_mem_q <= perf_mem_q + 32'd1;
            end
            if (state_q == ARB_IDLE && IF_REQ && MEM_REQ) begin
                perf_cont_q <= perf_cont_q + 32'd1;
            end
        end
    end

    assign PERF_IF_GNT  = perf_if_q;
    assign PERF_MEM_GNT = perf_mem_q;
    assign PERF_CONTEND = perf_cont_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus hand sequences for contention,
// FLUSH and mid-transfer RESET.
module tb_mem_port_arbiter;

    logic        CLK;
    logic        RESET;
    logic        FLUSH;
    logic        IF_REQ;
    logic [63:0] IF_ADDR;
    logic        IF_GNT;
    logic        IF_RVALID;
    logic [63:0] IF_RDATA;
    logic        IF_ERR;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [63:0] MEM_ADDR;
    logic [63:0] MEM_WDATA;
    logic [7:0]  MEM_WSTRB;
    logic        MEM_GNT;
    logic        MEM_RVALID;
    logic [63:0] MEM_RDATA;
    logic        MEM_ERR;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic [63:0] BUS_ADDR;
    logic [63:0] BUS_WDATA;
    logic [7:0]  BUS_WSTRB;
    logic        BUS_ACK;
    logic [63:0] BUS_RDATA;
    logic        BUS_ERR;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] PERF_IF_GNT, PERF_MEM_GNT, PERF_CONTEND;
`endif

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .FLUSH      (FLUSH),
        .IF_REQ     (IF_REQ),
        .IF_ADDR    (IF_ADDR),
        .IF_GNT     (IF_GNT),
        .IF_RVALID  (IF_RVALID),
        .IF_RDATA   (IF_RDATA),
        .IF_ERR     (IF_ERR),
        .MEM_REQ    (MEM_REQ),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_WSTRB  (MEM_WSTRB),
        .MEM_GNT    (MEM_GNT),
        .MEM_RVALID (MEM_RVALID),
        .MEM_RDATA  (MEM_RDATA),
        .MEM_ERR    (MEM_ERR),
        .BUS_REQ    (BUS_REQ),
        .BUS_WE     (BUS_WE),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_WDATA  (BUS_WDATA),
        .BUS_WSTRB  (BUS_WSTRB),
        .BUS_ACK    (BUS_ACK),
        .BUS_RDATA  (BUS_RDATA),
        .BUS_ERR    (BUS_ERR)
`ifdef ARB_PERF_CNT_EN
        ,
        .PERF_IF_GNT  (PERF_IF_GNT),
        .PERF_MEM_GNT (PERF_MEM_GNT),
        .PERF_CONTEND (PERF_CONTEND)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // in : {rst, flush, if_req, mem_req, mem_we, ack, err}
    // ef : {if_gnt, mem_gnt, bus_req, bus_we, if_rvalid, if_err, mem_rvalid, mem_err}
    typedef struct {
        logic [6:0]  in;
        logic [63:0] brd;
        logic [7:0]  ef;
        logic [15:0] ea;
        logic [7:0]  ews;
        logic [63:0] ewd;
        logic [63:0] eird;
        logic [63:0] emrd;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        FLUSH     = 1'b0;
        IF_REQ    = 1'b0;
        MEM_REQ   = 1'b0;
        MEM_WE    = 1'b0;
        BUS_ACK   = 1'b0;
        BUS_ERR   = 1'b0;
        BUS_RDATA = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        cyc();
        cyc();
        RESET = 1'b0;
    endtask

    localparam logic [63:0] D13 = 64'hDEADBEEF_00000013;
    localparam logic [63:0] WD  = 64'h11223344_55667788;

    initial begin
        int n;
        int exp_owner[10];
        exp_owner = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        tbl[0]  = '{7'b1000000, 64'h0, 8'b00000000, 16'h0000, 8'h00, 64'h0, 64'h0, 64'h0};
        tbl[1]  = '{7'b0010000, 64'h0, 8'b10000000, 16'h0000, 8'h00, 64'h0, 64'h0, 64'h0};
        tbl[2]  = '{7'b0000000, 64'h0, 8'b00100000, 16'h1000, 8'h00, 64'h0, 64'h0, 64'h0};
        tbl[3]  = '{7'b0000000, 64'h0, 8'b00100000, 16'h1000, 8'h00, 64'h0, 64'h0, 64'h0};
        tbl[4]  = '{7'b0000000, 64'h0, 8'b00100000, 16'h1000, 8'h00, 64'h0, 64'h0, 64'h0};
        tbl[5]  = '{7'b0000010, D13,   8'b00100000, 16'h1000, 8'h00, 64'h0, 64'h0, 64'h0};
        tbl[6]  = '{7'b0000000, 64'h0, 8'b00001000, 16'h1000, 8'h00, 64'h0, D13,   64'h0};
        tbl[7]  = '{7'b0000000, 64'h0, 8'b00000000, 16'h1000, 8'h00, 64'h0, D13,   64'h0};
        tbl[8]  = '{7'b0001100, 64'h0, 8'b01000000, 16'h1000, 8'h00, 64'h0, D13,   64'h0};
        tbl[9]  = '{7'b0000000, 64'h0, 8'b00110000, 16'h2008, 8'h0F, WD,    D13,   64'h0};
        tbl[10] = '{7'b0000000, 64'h0, 8'b00110000, 16'h2008, 8'h0F, WD,    D13,   64'h0};
        tbl[11] = '{7'b0000010, 64'h0, 8'b00110000, 16'h2008, 8'h0F, WD,    D13,   64'h0};
        tbl[12] = '{7'b0000000, 64'h0, 8'b00010010, 16'h2008, 8'h0F, WD,    D13,   64'h0};
        tbl[13] = '{7'b0001000, 64'h0, 8'b01010000, 16'h2008, 8'h0F, WD,    D13,   64'h0};
        tbl[14] = '{7'b0000011, 64'h5555555555555555, 8'b00100000, 16'h2008, 8'h0F, WD, D13,
                    64'h0};
        tbl[15] = '{7'b0000000, 64'h0, 8'b00000011, 16'h2008, 8'h0F, WD,    D13,   64'h0};
        tbl[16] = '{7'b0001000, 64'h0, 8'b01000001, 16'h2008, 8'h0F, WD,    D13,   64'h0};
        tbl[17] = '{7'b0000010, 64'h0123456789ABCDEF, 8'b00100001, 16'h2008, 8'h0F, WD, D13,
                    64'h0};
        tbl[18] = '{7'b0000000, 64'h0, 8'b00000010, 16'h2008, 8'h0F, WD, D13,
                    64'h0123456789ABCDEF};

        IF_ADDR   = 64'h1000;
        MEM_ADDR  = 64'h2008;
        MEM_WDATA = WD;
        MEM_WSTRB = 8'h0F;
        do_reset();

        for (int i = 0; i < 19; i++) begin
            cyc();
            {RESET, FLUSH, IF_REQ, MEM_REQ, MEM_WE, BUS_ACK, BUS_ERR} = tbl[i].in;
            BUS_RDATA = tbl[i].brd;
            mid();
            chk($sformatf("vec%0d_flags", i),
                {IF_GNT, MEM_GNT, BUS_REQ, BUS_WE, IF_RVALID, IF_ERR, MEM_RVALID, MEM_ERR},
                tbl[i].ef);
            chk($sformatf("vec%0d_bus_addr", i), BUS_ADDR, {48'h0, tbl[i].ea});
            chk($sformatf("vec%0d_bus_wstrb", i), BUS_WSTRB, tbl[i].ews);
            chk($sformatf("vec%0d_bus_wdata", i), BUS_WDATA, tbl[i].ewd);
            chk($sformatf("vec%0d_if_rdata", i), IF_RDATA, tbl[i].eird);
            chk($sformatf("vec%0d_mem_rdata", i), MEM_RDATA, tbl[i].emrd);
        end

        // Contention with zero-wait memory: fetch wins once every MAX_WAIT+1 grants.
        do_reset();
        IF_ADDR  = 64'h1000;
        MEM_ADDR = 64'h2000;
        IF_REQ   = 1'b1;
        MEM_REQ  = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            if (c > 0) cyc();
            BUS_ACK = BUS_REQ;
            mid();
            chk("contend_onehot", IF_GNT & MEM_GNT, 0);
            if (IF_GNT || MEM_GNT) begin
                chk($sformatf("contend_gnt%0d_is_mem", n), MEM_GNT, exp_owner[n]);
                n++;
            end
        end
        chk("contend_grant_count", n, 10);

        // FLUSH: blocks an idle fetch grant, then kills an outstanding fetch response.
        do_reset();
        IF_REQ  = 1'b1;
        IF_ADDR = 64'h1000;
        FLUSH   = 1'b1;
        mid();
        chk("flush_idle_if_gnt", IF_GNT, 0);
        cyc();
        FLUSH = 1'b0;
        mid();
        chk("fetch_gnt", IF_GNT, 1);
        cyc();
        IF_REQ = 1'b0;
        FLUSH  = 1'b1;
        mid();
        chk("flush_busy_bus_req", BUS_REQ, 1);
        cyc();
        FLUSH = 1'b0;
        mid();
        chk("flush_busy_no_rvalid", IF_RVALID, 0);
        cyc();
        BUS_ACK   = 1'b1;
        BUS_RDATA = 64'h99;
        mid();
        chk("flush_ack_bus_req", BUS_REQ, 1);
        cyc();
        BUS_ACK = 1'b0;
        IF_REQ  = 1'b1;
        IF_ADDR = 64'h3000;
        mid();
        chk("flush_killed_rvalid", IF_RVALID, 0);
        chk("flush_killed_rdata", IF_RDATA, 0);
        chk("regrant_after_ack", IF_GNT, 1);
        cyc();
        IF_REQ    = 1'b0;
        BUS_ACK   = 1'b1;
        BUS_RDATA = 64'h77;
        mid();
        chk("regrant_bus_addr", BUS_ADDR, 64'h3000);
        chk("regrant_bus_req", BUS_REQ, 1);
        cyc();
        BUS_ACK = 1'b0;
        mid();
        chk("regrant_rvalid", IF_RVALID, 1);
        chk("regrant_rdata", IF_RDATA, 64'h77);
        // FLUSH coinciding with the fetch ACK.
        cyc();
        IF_REQ  = 1'b1;
        IF_ADDR = 64'h1008;
        mid();
        chk("late_flush_gnt", IF_GNT, 1);
        cyc();
        IF_REQ    = 1'b0;
        BUS_ACK   = 1'b1;
        FLUSH     = 1'b1;
        BUS_RDATA = 64'h55;
        mid();
        cyc();
        BUS_ACK = 1'b0;
        FLUSH   = 1'b0;
        mid();
        chk("late_flush_no_rvalid", IF_RVALID, 0);
        chk("late_flush_rdata_held", IF_RDATA, 64'h77);
        chk("late_flush_bus_idle", BUS_REQ, 0);

        // RESET during a memory transfer, then a late ACK that must be ignored.
        do_reset();
        MEM_REQ  = 1'b1;
        MEM_WE   = 1'b0;
        MEM_ADDR = 64'h4000;
        mid();
        chk("rst_mem_gnt", MEM_GNT, 1);
        cyc();
        MEM_REQ = 1'b0;
        mid();
        chk("rst_bus_addr_before", BUS_ADDR, 64'h4000);
        cyc();
        RESET = 1'b1;
        mid();
        chk("rst_sync_bus_req", BUS_REQ, 1);
        cyc();
        RESET     = 1'b0;
        BUS_ACK   = 1'b1;
        BUS_RDATA = 64'hABCD;
        mid();
        chk("rst_outputs_zero",
            {IF_GNT, MEM_GNT, BUS_REQ, BUS_WE, IF_RVALID, IF_ERR, MEM_RVALID, MEM_ERR}, 0);
        chk("rst_bus_addr", BUS_ADDR, 0);
        cyc();
        BUS_ACK = 1'b0;
        mid();
        chk("rst_late_ack_rvalid", MEM_RVALID, 0);
        chk("rst_late_ack_rdata", MEM_RDATA, 0);
        // FLUSH is held through this transfer and must not affect it.
        cyc();
        MEM_REQ  = 1'b1;
        MEM_ADDR = 64'h4010;
        FLUSH    = 1'b1;
        mid();
        chk("post_rst_gnt", MEM_GNT, 1);
        cyc();
        MEM_REQ   = 1'b0;
        BUS_ACK   = 1'b1;
        BUS_RDATA = 64'h1234;
        mid();
        chk("post_rst_bus_addr", BUS_ADDR, 64'h4010);
        cyc();
        BUS_ACK = 1'b0;
        FLUSH   = 1'b0;
        mid();
        chk("post_rst_rvalid", MEM_RVALID, 1);
        chk("post_rst_rdata", MEM_RDATA, 64'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one backing memory port between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage RV64 pipeline.
- Serializes requests, holds the bus request until it is acknowledged, and routes each response back to its owner.
- Drops fetch responses that a writeback redirect (branch/trap) has made stale.
- Sits between the fetch/memory stages and the single-ported unified memory. Its per-requester grant/valid signals drive the fetch and memory-stage stall logic.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.
- MAX_WAIT, 4, consecutive lost arbitrations after which a fetch request beats a memory request (legal range 1..15).

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- FLUSH  in  1  writeback redirect (PC mux/trap); kills the outstanding fetch
- IF_REQ  in  1  fetch read request, held until IF_GNT
- IF_ADDR  in  ADDR_W  fetch address
- IF_GNT  out  1  fetch request accepted this cycle
- IF_RVALID  out  1  fetch response valid (1-cycle pulse)
- IF_RDATA  out  DATA_W  fetch read data
- IF_ERR  out  1  access fault, valid with IF_RVALID
- MEM_REQ  in  1  memory-stage request, held until MEM_GNT
- MEM_WE  in  1  1 = store
- MEM_ADDR  in  ADDR_W  data address
- MEM_WDATA  in  DATA_W  store data
- MEM_WSTRB  in  DATA_W/8  byte enables
- MEM_GNT  out  1  memory request accepted this cycle
- MEM_RVALID  out  1  memory response valid (1-cycle pulse; also for stores)
- MEM_RDATA  out  DATA_W  load data
- MEM_ERR  out  1  access fault, valid with MEM_RVALID
- BUS_REQ  out  1  backing request, held until BUS_ACK
- BUS_WE  out  1  write enable
- BUS_ADDR  out  ADDR_W  address
- BUS_WDATA  out  DATA_W  write data
- BUS_WSTRB  out  DATA_W/8  byte enables
- BUS_ACK  in  1  transfer complete
- BUS_RDATA  in  DATA_W  read data, valid with BUS_ACK
- BUS_ERR  in  1  fault, valid with BUS_ACK

Behaviour:
- Clock and reset: single clock CLK; RESET is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, wait counter 0, kill flag 0.
- States:
  - IDLE: no transfer outstanding.
  - BUSY_IF: fetch transfer outstanding.
  - BUSY_MEM: memory transfer outstanding.
- Arbitration (IDLE only): IF_GNT and MEM_GNT are combinational, one-hot, and asserted only in IDLE with RESET low.
  - MEM_REQ only: MEM wins.
  - IF_REQ only: IF wins.
  - Both requesting: MEM wins unless the wait counter equals MAX_WAIT, in which case IF wins.
- Wait counter:
  - Increments on each cycle IF_REQ loses to MEM, saturating at MAX_WAIT.
  - Clears on IF_GNT, and on any IDLE cycle with IF_REQ low.
- Grant edge: the request fields are latched into bus registers, and the state moves to BUSY_IF or BUSY_MEM.
- Bus hold: BUS_REQ is registered, asserted from the cycle after the grant, and held with stable fields until BUS_ACK.
- Ack edge:
  - BUS_REQ deasserts and the state returns to IDLE.
  - The owner's RVALID/RDATA/ERR are registered for exactly one cycle.
  - A new grant is allowed in that same RVALID cycle, giving back-to-back transfers.
- Minimum latency with zero-wait memory: grant at cycle 0, BUS_REQ at cycle 1, ACK at cycle 1, RVALID at cycle 2.
- FLUSH:
  - In BUSY_IF: sets the kill flag. The bus transfer still completes (no abort), but IF_RVALID is suppressed on ACK and the kill flag clears.
  - In IDLE with IF_REQ: IF_GNT is forced 0 that cycle.
  - Has no effect on MEM transfers.
- FLUSH in the same cycle as the BUS_ACK of an IF transfer: the response is suppressed.
- RESET in mid-transfer: returns to IDLE immediately, and any later BUS_ACK is ignored. The memory model must tolerate a dropped request.
- RDATA and ERR hold their last values when RVALID is low.
- BUS_ERR is passed through to the owner's ERR with RDATA forced to 0.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Enabled:
  - Adds 32-bit output ports PERF_IF_GNT, PERF_MEM_GNT and PERF_CONTEND.
  - PERF_CONTEND counts IDLE cycles with both IF_REQ and MEM_REQ high.
  - All three wrap at 2^32 and clear on RESET.
- Disabled: the ports and counters are absent.

Decomposition:
- Shared package arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_MEM);
  - owner encoding constants OWN_IF=0, OWN_MEM=1;
  - the default MAX_WAIT.
- One natural sub-module: arb_prio_sel, the combinational priority select plus the saturating wait counter.

Test Plan:
- Single fetch of 0x1000, memory ACK 3 cycles after BUS_REQ -> IF_GNT at cycle 0; BUS_REQ at cycles 1-4; IF_RVALID at cycle 5 with BUS_RDATA 0xDEADBEEF_00000013.
- IF_REQ and MEM_REQ both held, zero-wait memory, MAX_WAIT=4 -> grants MEM,MEM,MEM,MEM,IF,MEM...; wait counter clears after the IF grant.
- Store to 0x2008 with WSTRB 0x0F -> BUS_WE=1 and BUS_WSTRB=0x0F held until ACK; MEM_RVALID pulses once; IF_RVALID stays 0.
- FLUSH 1 cycle after IF_GNT, ACK 2 cycles later -> no IF_RVALID; the next IF_REQ to 0x3000 is granted in the cycle after the ACK edge.
- BUS_ERR with ACK on a load -> MEM_RVALID=1, MEM_ERR=1, MEM_RDATA=0.
- RESET asserted in BUSY_MEM, late ACK arrives -> all outputs 0, state IDLE, no RVALID; next request served normally.
